// File: rtl/bin2bcd_if.sv
// Handshake and data bundle between a bin2bcd_seq converter and its requester.
// The master drives start/bin_in. The slave returns status and the packed BCD result.
interface bin2bcd_if #(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5
);
    logic                  start;
    logic [BIN_W-1:0]      bin_in;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd_out;
    logic                  sign_out;
    logic                  overflow;

    modport master (
        output start, bin_in,
        input  busy, done, bcd_out, sign_out, overflow
    );

    modport slave (
        input  start, bin_in,
        output busy, done, bcd_out, sign_out, overflow
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one add-3/shift iteration per clock.
// Supports an optional signed mode, where the output is magnitude plus sign, and sticky overflow detection.
module bin2bcd_seq #(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5,
    parameter int SIGNED = 0
) (
    input  logic       clk,
    input  logic       reset,
    bin2bcd_if.slave   bus
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int SH_W  = BCD_W + BIN_W;
    localparam int CNT_W = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_r;
    logic [SH_W-1:0]    sh_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               sign_r;
    logic               ovf_acc_r;
    logic               busy_r;
    logic               done_r;
    logic [BCD_W-1:0]   bcd_r;
    logic               sign_out_r;
    logic               ovf_out_r;

    logic [SH_W-1:0]    adj_s;
    logic [SH_W-1:0]    shifted_s;
    logic               carry_s;
    logic               last_s;

    // Every BCD digit above 4 gets +3. All digits are judged on their pre-shift value.
    function automatic logic [SH_W-1:0] add3_adjust(input logic [SH_W-1:0] v);
        logic [SH_W-1:0] r;
        r = v;
        for (int d = 0; d < DIGITS; d++) begin
            if (v[BIN_W + 4*d +: 4] > 4'd4) begin
                r[BIN_W + 4*d +: 4] = v[BIN_W + 4*d +: 4] + 4'd3;
            end else begin
                r[BIN_W + 4*d +: 4] = v[BIN_W + 4*d +: 4];
            end
        end
        return r;
    endfunction

    function automatic logic is_negative(input logic [BIN_W-1:0] v);
        return (SIGNED != 0) && v[BIN_W-1];
    endfunction

    // Unsigned BIN_W-bit result, so the most negative operand maps exactly to 2^(BIN_W-1).
    function automatic logic [BIN_W-1:0] magnitude(input logic [BIN_W-1:0] v);
        if (is_negative(v)) begin
            return (~v) + {{(BIN_W-1){1'b0}}, 1'b1};
        end else begin
            return v;
        end
    endfunction

    // One double-dabble step: parallel adjust, then shift of the whole {bcd, bin} register.
    always_comb begin
        adj_s     = add3_adjust(sh_r);
        shifted_s = {adj_s[SH_W-2:0], 1'b0};
        carry_s   = adj_s[SH_W-1];
        last_s    = (cnt_r == CNT_W'(BIN_W - 1));
    end

    // Control FSM, iteration datapath and registered result outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            sh_r       <= {SH_W{1'b0}};
            cnt_r      <= {CNT_W{1'b0}};
            sign_r     <= 1'b0;
            ovf_acc_r  <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            bcd_r      <= {BCD_W{1'b0}};
            sign_out_r <= 1'b0;
            ovf_out_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        sh_r      <= {{BCD_W{1'b0}}, magnitude(bus.bin_in)};
                        sign_r    <= is_negative(bus.bin_in);
                        cnt_r     <= {CNT_W{1'b0}};
                        ovf_acc_r <= 1'b0;
                        busy_r    <= 1'b1;
                        state_r   <= CONV;
                    end else begin
                        busy_r    <= 1'b0;
                        state_r   <= IDLE;
                    end
                end
                CONV: begin
                    sh_r      <= shifted_s;
                    // A digit carry falling off the top means the value needs more than DIGITS digits.
                    ovf_acc_r <= ovf_acc_r | carry_s;
                    cnt_r     <= cnt_r + CNT_W'(1);
                    if (last_s) begin
                        state_r <= DONE;
                    end else begin
                        state_r <= CONV;
                    end
                end
                DONE: begin
                    bcd_r      <= sh_r[SH_W-1:BIN_W];
                    sign_out_r <= sign_r;
                    ovf_out_r  <= ovf_acc_r;
                    done_r     <= 1'b1;
                    busy_r     <= 1'b0;
                    state_r    <= IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.bcd_out  = bcd_r;
    assign bus.sign_out = sign_out_r;
    assign bus.overflow = ovf_out_r;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq. It runs five parameter sets side by side against an arithmetic reference model.
module tb_bin2bcd_seq;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [4:0]         start_v;
    logic [4:0][31:0]   bin_v;
    logic [4:0]         busy_v, done_v, sign_v, ovf_v;
    logic [4:0][39:0]   bcd_v;
    int n_tests = 0;
    int n_fail  = 0;

    // Configurations (BIN_W/DIGITS/SIGNED): 0=16/5/0, 1=16/5/1, 2=16/4/0, 3=12/4/0, 4=8/3/1
    bin2bcd_if #(.BIN_W(16), .DIGITS(5)) if0 ();
    bin2bcd_if #(.BIN_W(16), .DIGITS(5)) if1 ();
    bin2bcd_if #(.BIN_W(16), .DIGITS(4)) if2 ();
    bin2bcd_if #(.BIN_W(12), .DIGITS(4)) if3 ();
    bin2bcd_if #(.BIN_W(8),  .DIGITS(3)) if4 ();

    bin2bcd_seq #(.BIN_W(16), .DIGITS(5), .SIGNED(0)) u0 (.clk(clk), .reset(reset), .bus(if0));
    bin2bcd_seq #(.BIN_W(16), .DIGITS(5), .SIGNED(1)) u1 (.clk(clk), .reset(reset), .bus(if1));
    bin2bcd_seq #(.BIN_W(16), .DIGITS(4), .SIGNED(0)) u2 (.clk(clk), .reset(reset), .bus(if2));
    bin2bcd_seq #(.BIN_W(12), .DIGITS(4), .SIGNED(0)) u3 (.clk(clk), .reset(reset), .bus(if3));
    bin2bcd_seq #(.BIN_W(8),  .DIGITS(3), .SIGNED(1)) u4 (.clk(clk), .reset(reset), .bus(if4));

    assign if0.start = start_v[0];  assign if0.bin_in = bin_v[0][15:0];
    assign if1.start = start_v[1];  assign if1.bin_in = bin_v[1][15:0];
    assign if2.start = start_v[2];  assign if2.bin_in = bin_v[2][15:0];
    assign if3.start = start_v[3];  assign if3.bin_in = bin_v[3][11:0];
    assign if4.start = start_v[4];  assign if4.bin_in = bin_v[4][7:0];

    assign busy_v = {if4.busy, if3.busy, if2.busy, if1.busy, if0.busy};
    assign done_v = {if4.done, if3.done, if2.done, if1.done, if0.done};
    assign sign_v = {if4.sign_out, if3.sign_out, if2.sign_out, if1.sign_out, if0.sign_out};
    assign ovf_v  = {if4.overflow, if3.overflow, if2.overflow, if1.overflow, if0.overflow};
    assign bcd_v[0] = 40'(if0.bcd_out);
    assign bcd_v[1] = 40'(if1.bcd_out);
    assign bcd_v[2] = 40'(if2.bcd_out);
    assign bcd_v[3] = 40'(if3.bcd_out);
    assign bcd_v[4] = 40'(if4.bcd_out);

    function automatic int cfg_bw(input int idx);
        case (idx)
            3:       return 12;
            4:       return 8;
            default: return 16;
        endcase
    endfunction

    function automatic int cfg_dg(input int idx);
        case (idx)
            2, 3:    return 4;
            4:       return 3;
            default: return 5;
        endcase
    endfunction

    function automatic int cfg_sg(input int idx);
        return (idx == 1 || idx == 4) ? 1 : 0;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Decimal digits by plain division; the sign is taken from the operand's signed value.
    function automatic void ref_model(input int idx, input logic [31:0] raw,
                                      output logic [39:0] bcd, output logic sgn, output logic ovf);
        longint unsigned one, v, mag, lim, m;
        int bw, dg;
        bw  = cfg_bw(idx);
        dg  = cfg_dg(idx);
        one = 1;
        v   = 64'(raw) & ((one << bw) - one);
        sgn = 1'b0;
        mag = v;
        if (cfg_sg(idx) != 0 && v >= (one << (bw - 1))) begin
            sgn = 1'b1;
            mag = (one << bw) - v;
        end
        lim = 1;
        for (int d = 0; d < dg; d++) lim = lim * 10;
        ovf = (mag >= lim);
        m   = mag % lim;
        bcd = 40'd0;
        for (int d = 0; d < dg; d++) begin
            bcd = bcd | (40'(m % 10) << (4 * d));
            m   = m / 10;
        end
    endfunction

    // Issue one start, then wait for done. lat counts the cycles from the accept edge to done.
    task automatic run_conv(input int idx, input logic [31:0] val, output int lat);
        @(negedge clk);
        bin_v[idx]   = val;
        start_v[idx] = 1'b1;
        @(negedge clk);
        start_v[idx] = 1'b0;
        check($sformatf("busy_after_start[%0d]", idx), 64'(busy_v[idx]), 64'd1);
        lat = 0;
        while (!done_v[idx] && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic check_result(input int idx, input logic [31:0] val);
        logic [39:0] e_bcd, b;
        logic e_sgn, e_ovf, bad;
        ref_model(idx, val, e_bcd, e_sgn, e_ovf);
        b   = bcd_v[idx];
        bad = 1'b0;
        for (int d = 0; d < cfg_dg(idx); d++) if (b[4*d +: 4] > 4'd9) bad = 1'b1;
        check($sformatf("bcd[%0d] op=0x%0h", idx, val), 64'(bcd_v[idx]), 64'(e_bcd));
        check($sformatf("sign[%0d] op=0x%0h", idx, val), 64'(sign_v[idx]), 64'(e_sgn));
        check($sformatf("ovf[%0d] op=0x%0h", idx, val), 64'(ovf_v[idx]), 64'(e_ovf));
        check($sformatf("digit_le9[%0d]", idx), 64'(bad), 64'd0);
    endtask

    task automatic conv_and_check(input int idx, input logic [31:0] val);
        int lat;
        run_conv(idx, val, lat);
        check($sformatf("latency[%0d]", idx), 64'(lat), 64'(cfg_bw(idx) + 1));
        check($sformatf("busy_in_done[%0d]", idx), 64'(busy_v[idx]), 64'd0);
        check_result(idx, val);
    endtask

    task automatic directed(input int idx, input logic [31:0] val,
                            input logic [39:0] e_bcd, input logic e_sgn, input logic e_ovf);
        int lat;
        run_conv(idx, val, lat);
        check($sformatf("dir_latency[%0d]", idx), 64'(lat), 64'(cfg_bw(idx) + 1));
        check($sformatf("dir_bcd[%0d] op=0x%0h", idx, val), 64'(bcd_v[idx]), 64'(e_bcd));
        check($sformatf("dir_sign[%0d] op=0x%0h", idx, val), 64'(sign_v[idx]), 64'(e_sgn));
        check($sformatf("dir_ovf[%0d] op=0x%0h", idx, val), 64'(ovf_v[idx]), 64'(e_ovf));
    endtask

    task automatic count_dones(input int idx, input int cycles, output int n);
        n = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (done_v[idx]) n++;
        end
    endtask

    initial begin
        int cnt, nd, changed;
        logic [39:0] prev;
        reset   = 1'b1;
        start_v = 5'd0;
        bin_v   = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("rst_busy[%0d]", i), 64'(busy_v[i]), 64'd0);
            check($sformatf("rst_done[%0d]", i), 64'(done_v[i]), 64'd0);
            check($sformatf("rst_bcd[%0d]", i),  64'(bcd_v[i]),  64'd0);
            check($sformatf("rst_sign[%0d]", i), 64'(sign_v[i]), 64'd0);
            check($sformatf("rst_ovf[%0d]", i),  64'(ovf_v[i]),  64'd0);
        end

        directed(0, 32'd65535,   40'h65535, 1'b0, 1'b0);
        directed(0, 32'd0,       40'h00000, 1'b0, 1'b0);
        directed(1, 32'h0000FB2E, 40'h01234, 1'b1, 1'b0);
        directed(1, 32'h00008000, 40'h32768, 1'b1, 1'b0);
        directed(1, 32'h00007FFF, 40'h32767, 1'b0, 1'b0);
        directed(2, 32'd12345,   40'h2345,  1'b0, 1'b1);
        directed(2, 32'd9999,    40'h9999,  1'b0, 1'b0);
        directed(4, 32'h00000080, 40'h128,  1'b1, 1'b0);

        // Start pulses and operand changes during CONV must be ignored.
        @(negedge clk);
        bin_v[0] = 32'd12345; start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0; cnt = 0;
        repeat (3) begin @(negedge clk); cnt++; end
        bin_v[0] = 32'd999; start_v[0] = 1'b1;
        @(negedge clk); cnt++;
        start_v[0] = 1'b0; bin_v[0] = 32'd54321;
        while (!done_v[0] && cnt < 100) begin @(negedge clk); cnt++; end
        check("ignore_latency", 64'(cnt), 64'd17);
        check("ignore_bcd", 64'(bcd_v[0]), 64'h12345);
        count_dones(0, 25, nd);
        check("ignore_single_done", 64'(nd), 64'd0);

        // Back-to-back: start raised in the done cycle; the old result must hold until the next done.
        conv_and_check(0, 32'd40000);
        prev = bcd_v[0];
        bin_v[0] = 32'd777; start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        check("done_one_cycle", 64'(done_v[0]), 64'd0);
        cnt = 0; changed = 0;
        while (!done_v[0] && cnt < 100) begin
            if (bcd_v[0] !== prev) changed = 1;
            @(negedge clk);
            cnt++;
        end
        check("b2b_latency", 64'(cnt), 64'd17);
        check("b2b_hold", 64'(changed), 64'd0);
        check("b2b_bcd", 64'(bcd_v[0]), 64'h00777);

        // Reset sampled on the 8th iteration edge aborts the conversion.
        @(negedge clk);
        bin_v[0] = 32'd50000; start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (7) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", 64'(busy_v[0]), 64'd0);
        check("abort_done", 64'(done_v[0]), 64'd0);
        check("abort_bcd",  64'(bcd_v[0]),  64'd0);
        check("abort_sign", 64'(sign_v[0]), 64'd0);
        check("abort_ovf",  64'(ovf_v[0]),  64'd0);
        count_dones(0, 25, nd);
        check("abort_no_done", 64'(nd), 64'd0);
        directed(0, 32'd4095, 40'h04095, 1'b0, 1'b0);

        // Random sweeps against the reference model.
        repeat (1000) conv_and_check(0, $urandom);
        repeat (1000) conv_and_check(3, $urandom);
        repeat (1000) conv_and_check(4, $urandom);
        repeat (50)   conv_and_check(1, $urandom);
        repeat (50)   conv_and_check(2, $urandom);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
